counter_sweep_ctrl: RTL and testbench
=====================================

Name: counter_sweep_ctrl

Overview:
Sequencer that drives an external loadable up/down counter through a triangle sweep: load `lo`, count up to `hi`, count down to `lo`, repeated N times, then park. The counter counts on every clock unless loaded. This block therefore owns all three counter control inputs (`ld`, `up_dn`, `d`) and watches the counter output `q` to decide each turn-around. It sits beside the counter in the lab datapath and exposes a start/done handshake to the top level.

Parameters:
- WIDTH, 8, counter data width (`lo`, `hi`, `q`, `d`, park register).
- SWEEP_W, 4, width of the sweep-count input and the remaining-sweeps register.

Ports:
- clk  in  1  system clock, all state changes on posedge.
- reset  in  1  asynchronous active-high reset.
- start  in  1  request a sweep sequence; sampled only in IDLE.
- abort  in  1  stop an active sweep and park at the current count.
- lo  in  WIDTH  lower sweep bound, unsigned; latched at accepted start.
- hi  in  WIDTH  upper sweep bound, unsigned; latched at accepted start.
- sweeps  in  SWEEP_W  number of full lo->hi->lo sweeps; latched at accepted start.
- q  in  WIDTH  counter output, fed back.
- ld  out  1  counter load enable.
- up_dn  out  1  counter direction: 1 = count down, 0 = count up.
- d  out  WIDTH  counter load data.
- busy  out  1  high in LOAD, UP, DOWN.
- done  out  1  one-cycle pulse in DONE.
- err  out  1  one-cycle pulse on a rejected start or a feedback fault.

Behaviour:
- Reset (async) state and registers:
  - state=IDLE; `lo_r`, `hi_r`, `park_r` = 0; `rem_r` = 0.
  - Outputs: `ld`=1, `d`=0, `up_dn`=0, `busy`=0, `done`=0, `err`=0.
  - Consequence: the counter is loaded to 0 on every clk edge while idle, even with its own reset low.
- Outputs are a Moore decode of the state plus latched registers; there is no combinational path from `q` to the outputs.
  - IDLE: `ld`=1, `d`=`park_r`, `up_dn`=0.
  - LOAD: `ld`=1, `d`=`lo_r`, `up_dn`=0.
  - UP: `ld`=0, `up_dn`=0, `d`=`lo_r`.
  - DOWN: `ld`=0, `up_dn`=1, `d`=`lo_r`.
  - DONE: `ld`=1, `d`=`lo_r`, `up_dn`=0, `done`=1.
- IDLE, `start`=1:
  - If `hi`>`lo` and `sweeps`!=0: latch `lo`/`hi`/`sweeps`, go to LOAD.
  - Otherwise: `err` pulses next cycle and the state stays IDLE.
- LOAD -> UP unconditionally. The counter holds `lo_r` after this edge.
- UP:
  - If `q`==`hi_r`-1: go to DOWN. The same edge counts the counter up to `hi_r`.
  - Else stay in UP.
- DOWN:
  - If `q`==`lo_r`+1: the counter reaches `lo_r` on this edge; decrement `rem_r`.
  - Then go to DONE if `rem_r`==1, else go to UP.
  - Else stay in DOWN.
- DONE -> IDLE, with `park_r` <= `lo_r`.
- Timing:
  - One sweep = 2*(`hi`-`lo`) clocks.
  - `done` is asserted 1 + `sweeps`*2*(`hi`-`lo`) + 1 cycles after the start-accept edge.
- Abort, in UP or DOWN with `abort`=1:
  - `park_r` <= `q`, go to IDLE, no `done`.
  - The counter steps once more on that edge, then is reloaded to the captured value on the next edge.
  - `abort` is ignored in IDLE, LOAD and DONE.
- Feedback fault, in UP or DOWN:
  - Trigger: `q`<`lo_r` or `q`>`hi_r`.
  - Response: `err` pulse, `park_r` <= `lo_r`, go to IDLE.
  - `abort` has priority over the fault check.
- `start` while `busy` is ignored and not queued.
- Boundaries:
  - `hi`=`lo`+1 gives single-step turn-arounds: UP and DOWN each last 1 cycle.
  - `hi`=2^WIDTH-1 and `lo`=0 are legal; arithmetic on the bounds never wraps because `hi`>`lo` is guaranteed.
- Reset asserted mid-sweep: immediate return to reset values. `park_r`=0, so the counter is driven to 0.

Test Plan:
- Reset released, idle 5 clocks -> `ld`=1, `d`=0 throughout; counter model `q`=0; `busy`=0.
- start with `lo`=3, `hi`=6, `sweeps`=2:
  - `q` sequence after LOAD: 3,4,5,6,5,4,3,4,5,6,5,4,3.
  - `done` pulses exactly once, 14 cycles after accept.
  - `q` then parks at 3.
- start with `lo`=10, `hi`=11, `sweeps`=1 -> `q`: 10,11,10; `up_dn` toggles every cycle; then `done`.
- start rejects:
  - `lo`=5, `hi`=5 -> single `err` pulse, `busy` stays 0.
  - `sweeps`=0 -> single `err` pulse, `busy` stays 0.
- Mid-sweep abort at `q`=7, with `lo`=0, `hi`=20 counting up -> `q`=8 for one cycle, then 7 held; no `done`.
- Bench forces the counter's own reset during UP, `q` drops to 0 with `lo`=4 -> `err` pulse, state IDLE, `q` reloaded to 4.
- Async reset asserted mid-DOWN, between clock edges -> `busy`=0 and `ld`=1/`d`=0 immediately; next edge `q`=0.

Source files
------------

// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl: drives an external loadable up/down counter through lo->hi->lo triangle sweeps.
module counter_sweep_ctrl #(
  parameter int WIDTH   = 8,
  parameter int SWEEP_W = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [WIDTH-1:0]   lo_i,
  input  logic [WIDTH-1:0]   hi_i,
  input  logic [SWEEP_W-1:0] sweeps_i,
  input  logic [WIDTH-1:0]   q_i,
  output logic               ld_o,
  output logic               up_dn_o,
  output logic [WIDTH-1:0]   d_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);
  typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN, DONE} state_t;
  localparam logic [WIDTH-1:0]   ONE  = 1;
  localparam logic [SWEEP_W-1:0] RONE = 1;
  state_t state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d, park_q, park_d;
  logic [SWEEP_W-1:0] rem_q, rem_d;
  logic err_q, err_d;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      park_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      park_q  <= park_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    park_d  = park_q;
    rem_d   = rem_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE:
        if (start_i) begin
          if (hi_i > lo_i && sweeps_i != '0) begin
            lo_d    = lo_i;
            hi_d    = hi_i;
            rem_d   = sweeps_i;
            state_d = LOAD;
          end else err_d = 1'b1;
        end
      LOAD: state_d = UP;
      UP, DOWN:
        // abort wins over the range check so a parked value is always the live count
        if (abort_i) begin
          park_d  = q_i;
          state_d = IDLE;
        end else if (q_i < lo_q || q_i > hi_q) begin
          err_d   = 1'b1;
          park_d  = lo_q;
          state_d = IDLE;
        end else if (state_q == UP && q_i == hi_q - ONE) state_d = DOWN;
        else if (state_q == DOWN && q_i == lo_q + ONE) begin
          rem_d   = rem_q - RONE;
          state_d = rem_q == RONE ? DONE : UP;
        end
      DONE: begin
        park_d  = lo_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign ld_o    = state_q == IDLE || state_q == LOAD || state_q == DONE;
  assign up_dn_o = state_q == DOWN;
  assign d_o     = state_q == IDLE ? park_q : lo_q;
  assign busy_o  = state_q == LOAD || state_q == UP || state_q == DOWN;
  assign done_o  = state_q == DONE;
  assign err_o   = err_q;
endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// tb_counter_sweep_ctrl: randomized and directed sweeps against a triangle-waveform reference model.
module tb_counter_sweep_ctrl;
  logic clk = 1'b0, reset = 1'b1, cnt_rst = 1'b0;
  logic start = 1'b0, abort = 1'b0;
  logic [7:0] lo = '0, hi = '0, q, d;
  logic [3:0] sweeps = '0;
  logic ld, up_dn, busy, done, err;
  int n_chk = 0, n_err = 0, park_m = 0;
  always #5 clk = ~clk;
  always_ff @(posedge clk or posedge cnt_rst)
    if (cnt_rst) q <= '0;
    else if (ld) q <= d;
    else q <= up_dn ? q - 8'd1 : q + 8'd1;
  counter_sweep_ctrl #(.WIDTH(8), .SWEEP_W(4)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
    .lo_i(lo), .hi_i(hi), .sweeps_i(sweeps), .q_i(q),
    .ld_o(ld), .up_dn_o(up_dn), .d_o(d), .busy_o(busy), .done_o(done), .err_o(err)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic go(input int l, input int h, input int n);
    lo = 8'(l); hi = 8'(h); sweeps = 4'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  // cycle k = k-th cycle after the accept edge; waveform is a triangle of period 2*(hi-lo)
  task automatic run_sweep(input int l, input int h, input int n);
    int s = h - l, len = n * 2 * (h - l), t, qe;
    lo = 8'(l); hi = 8'(h); sweeps = 4'(n); start = 1'b1;
    for (int k = 1; k <= len + 3; k++) begin
      @(negedge clk);
      t = k - 2;
      qe = k == 1 ? park_m : t > len ? l : l + ((t % (2 * s)) <= s ? t % (2 * s) : 2 * s - t % (2 * s));
      check("q", 32'(q), 32'(qe));
      check("done", 32'(done), 32'(k == len + 2));
      check("busy", 32'(busy), 32'(k <= len + 1));
      check("up_dn", 32'(up_dn), 32'(k >= 2 && t < len && (t % (2 * s)) >= s));
      check("ld", 32'(ld), 32'(k == 1 || k >= len + 2));
      check("d", 32'(d), 32'(l));
      check("err", 32'(err), 32'd0);
      start = k < len + 2 ? 1'($urandom_range(0, 1)) : 1'b0;
      lo = 8'($urandom); hi = 8'($urandom); sweeps = 4'($urandom);
      abort = (k == 1 || k == len + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    abort = 1'b0;
    park_m = l;
  endtask
  task automatic reject(input int l, input int h, input int n);
    go(l, h, n);
    check("rej_err", 32'(err), 32'd1);
    check("rej_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("rej_err2", 32'(err), 32'd0);
    check("rej_busy2", 32'(busy), 32'd0);
    check("rej_q", 32'(q), 32'(park_m));
  endtask
  initial begin
    int l, s, n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("rst_ld", 32'(ld), 32'd1);
      check("rst_d", 32'(d), 32'd0);
      check("rst_q", 32'(q), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
    end
    run_sweep(3, 6, 2);
    run_sweep(10, 11, 1);
    reject(5, 5, 2);
    reject(1, 9, 0);
    go(0, 20, 1);
    repeat (8) @(negedge clk);
    check("abort_q_pre", 32'(q), 32'd7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_q_step", 32'(q), 32'd8);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_d", 32'(d), 32'd7);
    check("abort_done", 32'(done), 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("abort_q_hold", 32'(q), 32'd7);
      check("abort_done", 32'(done), 32'd0);
    end
    park_m = 7;
    go(4, 12, 1);
    repeat (3) @(negedge clk);
    check("fault_q_pre", 32'(q), 32'd6);
    cnt_rst = 1'b1;
    #1 cnt_rst = 1'b0;
    @(negedge clk);
    check("fault_err", 32'(err), 32'd1);
    check("fault_busy", 32'(busy), 32'd0);
    check("fault_q_step", 32'(q), 32'd1);
    @(negedge clk);
    check("fault_err2", 32'(err), 32'd0);
    check("fault_q_reload", 32'(q), 32'd4);
    check("fault_d", 32'(d), 32'd4);
    park_m = 4;
    go(3, 6, 1);
    repeat (6) @(negedge clk);
    check("mid_down_up_dn", 32'(up_dn), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ld", 32'(ld), 32'd1);
    check("arst_d", 32'(d), 32'd0);
    check("arst_up_dn", 32'(up_dn), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("arst_q", 32'(q), 32'd0);
    park_m = 0;
    run_sweep(0, 255, 1);
    for (int i = 0; i < 24; i++) begin
      l = $urandom_range(0, 200);
      s = $urandom_range(1, 20);
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) reject(l, l - $urandom_range(0, l), n);
        else reject(l, l + s, 0);
      end else run_sweep(l, l + s, n);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
